// File: rtl/pps_bus_bridge_pkg.sv
// Shared definitions for the system-side PPS register bridge: FSM states,
// PPS register indices (also used by pps_timer) and the command-word builder.
package pps_bus_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPush,
        StWaitResp,
        StPop,
        StLatch,
        StDone,
        StDrain,
        StDrain2
    } bridge_state_e;

    localparam logic [2:0] TS_LO      = 3'd0;
    localparam logic [2:0] TS_HI      = 3'd1;
    localparam logic [2:0] ACCUM_INCR = 3'd2;
    localparam logic [2:0] PPS_COUNT  = 3'd3;
    localparam logic [2:0] TIME_INCR  = 3'd4;
    localparam logic [2:0] EV_LO      = 3'd5;
    localparam logic [2:0] EV_HI      = 3'd6;

    localparam int unsigned CmdWidth = 36;
    localparam logic [3:0]  DropMax  = 4'd15;

    // Command word layout: {is_write, reg_idx, data}; reads carry zero data.
    function automatic logic [CmdWidth-1:0] make_cmd(input logic        is_write,
                                                     input logic [2:0]  reg_idx,
                                                     input logic [31:0] data);
        return {is_write, reg_idx, (is_write ? data : 32'h0)};
    endfunction

endpackage

// File: rtl/pps_bus_bridge_if.sv
// CPU-side bus plus the two async-FIFO ports of the PPS bridge.
// The bridge uses the slave view; the CPU/FIFO environment uses the master view.
interface pps_bus_bridge_if;
    import pps_bus_bridge_pkg::*;

    logic                sel;
    logic [4:0]          addr;
    logic [3:0]          wstrb;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                ready;
    logic [CmdWidth-1:0] data_to_pps;
    logic                to_pps_wr_en;
    logic                to_pps_full;
    logic [31:0]         data_from_pps;
    logic                from_pps_rd_en;
    logic                from_pps_empty;

    modport slave (
        input  sel, addr, wstrb, wdata, to_pps_full, data_from_pps, from_pps_empty,
        output rdata, ready, data_to_pps, to_pps_wr_en, from_pps_rd_en
    );

    modport master (
        output sel, addr, wstrb, wdata, to_pps_full, data_from_pps, from_pps_empty,
        input  rdata, ready, data_to_pps, to_pps_wr_en, from_pps_rd_en
    );

endinterface

// File: rtl/pps_bus_bridge.sv
// System-clock initiator for the PPS timer registers: turns CPU accesses into
// command words for the outgoing FIFO and completes reads from the return FIFO.
module pps_bus_bridge
    import pps_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 'd1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hdeadbeef
) (
    input logic             clk,
    input logic             reset_n,
    pps_bus_bridge_if.slave bus
);

    localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

    bridge_state_e       state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic [3:0]          drop_q, drop_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [CmdWidth-1:0] cmd_q, cmd_d;

    logic unused_addr;
    assign unused_addr = ^bus.addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            drop_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        ready_d = 1'b0;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Stale responses of timed-out reads go first so later reads pair up correctly.
                if (drop_q != 4'd0 && !bus.from_pps_empty) begin
                    rd_en_d = 1'b1;
                    state_d = StDrain;
                end else if (bus.sel && !bus.to_pps_full) begin
                    cmd_d   = make_cmd(|bus.wstrb, bus.addr[4:2], bus.wdata);
                    wr_en_d = 1'b1;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (cmd_q[CmdWidth-1]) begin
                    ready_d = 1'b1;
                    state_d = StDone;
                end else begin
                    timer_d = '0;
                    state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                if (!bus.from_pps_empty) begin
                    rd_en_d = 1'b1;
                    state_d = StPop;
                end else if (timer_q == TimerLast) begin
                    rdata_d = TIMEOUT_DATA;
                    ready_d = 1'b1;
                    if (drop_q != DropMax) begin
                        drop_d = drop_q + 4'd1;
                    end
                    state_d = StDone;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StPop: begin
                state_d = StLatch;
            end
            StLatch: begin
                rdata_d = bus.data_from_pps;
                ready_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StDrain: begin
                state_d = StDrain2;
            end
            StDrain2: begin
                drop_d  = drop_q - 4'd1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.rdata          = rdata_q;
    assign bus.ready          = ready_q;
    assign bus.data_to_pps    = cmd_q;
    assign bus.to_pps_wr_en   = wr_en_q;
    assign bus.from_pps_rd_en = rd_en_q;

endmodule

// File: tb/tb_pps_bus_bridge.sv
// Randomized self-checking bench for pps_bus_bridge with behavioural FIFO and
// transaction-level expectations.
module tb_pps_bus_bridge;
    import pps_bus_bridge_pkg::*;

    localparam int unsigned TO     = 64;
    localparam logic [31:0] TOData = 32'hdeadbeef;

    logic clk = 1'b0;
    logic reset_n;

    pps_bus_bridge_if bus ();

    pps_bus_bridge #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_DATA  (TOData)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          pops  = 0;
    int          m_drop = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] ret_q[$];
    int          pend_cyc[$];
    logic [31:0] pend_dat[$];

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and run the return-FIFO model there.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (bus.from_pps_rd_en && ret_q.size() > 0) begin
            bus.data_from_pps = ret_q.pop_front();
            pops++;
        end
        while (pend_cyc.size() > 0 && pend_cyc[0] <= cyc) begin
            ret_q.push_back(pend_dat[0]);
            void'(pend_cyc.pop_front());
            void'(pend_dat.pop_front());
        end
        bus.from_pps_empty = (ret_q.size() == 0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata);
        check({tag, "/rdata"}, 36'(bus.rdata), 36'(exp_rdata));
        check({tag, "/ready"}, 36'(bus.ready), 36'(0));
        check({tag, "/wr_en"}, 36'(bus.to_pps_wr_en), 36'(0));
        check({tag, "/rd_en"}, 36'(bus.from_pps_rd_en), 36'(0));
        check({tag, "/cmd"}, bus.data_to_pps, 36'(0));
    endtask

    // One CPU access. delay = cycles after the FIFO push until the PPS side
    // answers a read (0 = never answers).
    task automatic access(input string nm, input logic is_wr, input logic [4:0] a,
                          input logic [31:0] wd, input logic [3:0] strb, input int full_cyc,
                          input int delay, input logic [31:0] rsp);
        int          t0, wr_cyc, rdy_cyc, n_wr, n_rdy, extra, exp_wr, exp_rdy;
        logic [35:0] cmd_seen, exp_cmd;
        logic [31:0] exp_rd;

        // A pending stale response is drained first: DRAIN, DRAIN2, then IDLE again.
        extra = (m_drop > 0 && ret_q.size() > 0) ? 3 : 0;
        if (extra != 0) m_drop--;
        exp_cmd = {is_wr, a[4:2], (is_wr ? wd : 32'h0)};

        bus.sel         = 1'b1;
        bus.addr        = a;
        bus.wstrb       = is_wr ? strb : 4'h0;
        bus.wdata       = wd;
        bus.to_pps_full = (full_cyc > 0);
        t0       = cyc;
        wr_cyc   = -1;
        rdy_cyc  = -1;
        n_wr     = 0;
        n_rdy    = 0;
        cmd_seen = '0;
        exp_wr   = t0 + ((full_cyc > extra) ? full_cyc : extra) + 1;

        for (int k = 0; k < int'(TO) + 40 && rdy_cyc < 0; k++) begin
            cycle();
            if (cyc - t0 == full_cyc) bus.to_pps_full = 1'b0;
            if (bus.to_pps_wr_en) begin
                n_wr++;
                wr_cyc   = cyc;
                cmd_seen = bus.data_to_pps;
                if (!is_wr && delay > 0) begin
                    pend_cyc.push_back(cyc + delay);
                    pend_dat.push_back(rsp);
                end
            end
            if (bus.ready) begin
                n_rdy++;
                rdy_cyc = cyc;
            end
        end
        check({nm, "/completed"}, 36'(rdy_cyc >= 0), 36'(1));
        bus.sel = 1'b0;

        if (is_wr) begin
            exp_rdy = exp_wr + 1;
            exp_rd  = m_rdata;
        end else if (delay > 0 && delay <= int'(TO)) begin
            exp_rdy = exp_wr + delay + 3;
            exp_rd  = rsp;
        end else begin
            // No answer within the window: the timer runs TO cycles after PUSH.
            exp_rdy = exp_wr + int'(TO) + 1;
            exp_rd  = TOData;
            if (m_drop < 15) m_drop++;
        end
        m_rdata = exp_rd;

        cycle();
        if (bus.to_pps_wr_en) n_wr++;
        if (bus.ready) n_rdy++;

        check({nm, "/wr_cyc"}, 36'(wr_cyc - t0), 36'(exp_wr - t0));
        check({nm, "/rdy_cyc"}, 36'(rdy_cyc - t0), 36'(exp_rdy - t0));
        check({nm, "/cmd"}, cmd_seen, exp_cmd);
        check({nm, "/n_wr"}, 36'(n_wr), 36'(1));
        check({nm, "/n_rdy"}, 36'(n_rdy), 36'(1));
        check({nm, "/rdata"}, 36'(bus.rdata), 36'(exp_rd));
    endtask

    initial begin
        int p0;
        reset_n            = 1'b0;
        bus.sel            = 1'b0;
        bus.addr           = '0;
        bus.wstrb          = '0;
        bus.wdata          = '0;
        bus.to_pps_full    = 1'b0;
        bus.data_from_pps  = '0;
        bus.from_pps_empty = 1'b1;
        repeat (3) cycle();
        check_idle_outputs("reset", 32'h0);
        reset_n = 1'b1;
        cycle();

        access("wr08", 1'b1, 5'h08, 32'h12345678, 4'hf, 0, 0, 32'h0);
        access("rd04", 1'b0, 5'h04, 32'hffffffff, 4'h0, 0, 5, 32'h0000abcd);
        access("wr_full", 1'b1, 5'h10, 32'hcafef00d, 4'h1, 10, 0, 32'h0);
        access("b2b_wr", 1'b1, 5'h0c, 32'h0badf00d, 4'h3, 0, 0, 32'h0);
        access("b2b_rd", 1'b0, 5'h14, 32'h0, 4'h0, 0, 1, 32'h5a5a1234);
        // Answer lands exactly on the timer's last cycle and must win.
        access("rd_edge", 1'b0, 5'h18, 32'h0, 4'h0, 0, int'(TO), 32'h600dcafe);

        access("rd_to", 1'b0, 5'h00, 32'h0, 4'h0, 0, 0, 32'h0);
        ret_q.push_back(32'h11);
        bus.from_pps_empty = 1'b0;
        p0 = pops;
        access("rd_after_to", 1'b0, 5'h04, 32'h0, 4'h0, 0, 3, 32'h22);
        check("drain/pops", 36'(pops - p0), 36'(2));

        for (int i = 0; i < 30; i++) begin
            logic is_wr;
            is_wr = 1'($urandom_range(0, 1));
            access($sformatf("rnd%0d", i), is_wr, 5'($urandom), $urandom,
                   4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 8)), $urandom);
            repeat ($urandom_range(0, 2)) cycle();
        end

        // Reset while waiting on a read response.
        access("pre_rst", 1'b0, 5'h08, 32'h0, 4'h0, 0, 2, 32'h77aa55ee);
        bus.sel   = 1'b1;
        bus.addr  = 5'h1c;
        bus.wstrb = 4'h0;
        repeat (10) cycle();
        reset_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst", 32'h0);
        bus.sel = 1'b0;
        ret_q.delete();
        pend_cyc.delete();
        pend_dat.delete();
        bus.from_pps_empty = 1'b1;
        m_drop  = 0;
        m_rdata = '0;
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        access("post_rst", 1'b0, 5'h1c, 32'h0, 4'h0, 0, 4, 32'h13572468);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
